// File: rtl/conv_word_encoder.sv
// Rate-1/2 K=3 convolutional byte encoder: one bit per cycle, LSB first, packed into a
// 16-bit symbol word behind a one-word output buffer with valid/ready backpressure.
module conv_word_encoder #(
   parameter logic [2:0]  G0    = 3'b111,
   parameter logic [2:0]  G1    = 3'b101,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [15:0]      out_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

   state_t           r_state;
   logic             r_s1;
   logic             r_s2;
   logic [2:0]       r_bit;
   logic [7:0]       r_sreg;
   logic [15:0]      r_acc;
   logic             r_last_tag;
   logic [15:0]      r_out_word;
   logic             r_out_valid;
   logic             r_out_last;
   logic [CNT_W-1:0] r_cnt;

   logic             w_d;
   logic [2:0]       w_taps;
   logic             w_b0;
   logic             w_b1;
   logic             w_free;
   logic             w_consume;

   assign w_d       = r_sreg[0];
   assign w_taps    = {w_d, r_s1, r_s2};
   assign w_b0      = ^(w_taps & G0);
   assign w_b1      = ^(w_taps & G1);
   assign w_consume = r_out_valid & out_ready;
   assign w_free    = !r_out_valid || out_ready;

   assign in_ready  = (r_state == S_IDLE) && !flush;
   assign busy      = (r_state != S_IDLE);
   assign out_word  = r_out_word;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign word_cnt  = r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_s1        <= 1'b0;
         r_s2        <= 1'b0;
         r_bit       <= '0;
         r_sreg      <= '0;
         r_acc       <= '0;
         r_last_tag  <= 1'b0;
         r_out_word  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_cnt       <= '0;
      end else begin
         if (w_consume) begin
            r_cnt       <= r_cnt + 1'b1;
            r_out_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (flush) begin
                  r_sreg     <= '0;
                  r_last_tag <= 1'b1;
                  r_bit      <= '0;
                  r_state    <= S_SHIFT;
               end else if (in_valid) begin
                  r_sreg     <= in_data;
                  r_last_tag <= 1'b0;
                  r_bit      <= '0;
                  r_state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // Symbols enter at the top so symbol 0 ends up in bits [1:0] after 8 shifts.
               r_acc  <= {w_b1, w_b0, r_acc[15:2]};
               r_sreg <= r_sreg >> 1;
               r_s1   <= w_d;
               r_s2   <= r_s1;
               r_bit  <= r_bit + 1'b1;
               if (r_bit == 3'd7) r_state <= S_HOLD;
            end
            S_HOLD: begin
               // A load in the same cycle as a consume keeps out_valid asserted.
               if (w_free) begin
                  r_out_word  <= r_acc;
                  r_out_valid <= 1'b1;
                  r_out_last  <= r_last_tag;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
